// File: rtl/mvau_inp_ctrl.sv
// mvau_inp_ctrl: input buffer controller for the MVAU, writes each activation vector once and replays it for all NF row tiles.
module mvau_inp_ctrl #(
  parameter int MatrixW = 20,
  parameter int MatrixH = 8,
  parameter int SIMD = 2,
  parameter int PE = 2,
  localparam int SF = MatrixW / SIMD,
  localparam int NF = MatrixH / PE,
  localparam int BUF_ADDR = SF > 1 ? $clog2(SF) : 1,
  localparam int WMEM_ADDR = SF * NF > 1 ? $clog2(SF * NF) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_v,
  output logic                 in_rdy,
  input  logic                 out_rdy,
  output logic                 out_v,
  output logic                 write_en,
  output logic                 read_en,
  output logic [BUF_ADDR-1:0]  addr,
  output logic [WMEM_ADDR-1:0] wmem_addr,
  output logic                 sf_last,
  output logic                 vec_last
);
  localparam int NF_W = NF > 1 ? $clog2(NF) : 1;
  typedef enum logic {WRITE, READ} state_t;
  if (MatrixW % SIMD != 0 || MatrixH % PE != 0) begin : g_bad_fold
    $error("mvau_inp_ctrl: MatrixW must divide by SIMD and MatrixH by PE");
  end
  state_t               state_q, state_d;
  logic [BUF_ADDR-1:0]  sf_q, sf_d;
  logic [NF_W-1:0]      nf_q, nf_d;
  logic [WMEM_ADDR-1:0] wm_q, wm_d;
  logic                 wr, sf_end, nf_end, fire;
  always_comb begin
    wr      = state_q == WRITE;
    sf_end  = sf_q == BUF_ADDR'(SF - 1);
    nf_end  = nf_q == NF_W'(NF - 1);
    fire    = ~rst & (wr ? in_v & out_rdy : out_rdy);
    sf_d    = fire ? (sf_end ? '0 : sf_q + 1'b1) : sf_q;
    nf_d    = fire & sf_end ? (nf_end ? '0 : nf_q + 1'b1) : nf_q;
    wm_d    = fire ? (sf_end & nf_end ? '0 : wm_q + 1'b1) : wm_q;
    state_d = fire & sf_end ? (nf_end ? WRITE : READ) : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WRITE;
      sf_q    <= '0;
      nf_q    <= '0;
      wm_q    <= '0;
    end else begin
      state_q <= state_d;
      sf_q    <= sf_d;
      nf_q    <= nf_d;
      wm_q    <= wm_d;
    end
  end
  // Outputs are forced low during reset, including the pass-through ready.
  always_comb begin
    out_v     = fire;
    in_rdy    = ~rst & wr & out_rdy;
    write_en  = wr & fire;
    read_en   = ~rst & ~wr;
    addr      = rst ? '0 : sf_q;
    wmem_addr = rst ? '0 : wm_q;
    sf_last   = fire & sf_end;
    vec_last  = fire & sf_end & nf_end;
  end
endmodule
